// File: rtl/unified_mem_ctrl_if.sv
// Core-to-memory bus: the core's address/data/strobe lines plus the memory's
// load data, completion pulse, sticky error flag and MMIO output register.
interface unified_mem_ctrl_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemReq;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
    logic [31:0] mmio_out;

    modport master (
        output Address, WriteData, MemWrite, MemReq,
        input  ReadData, MemReady, MemErr, mmio_out
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemReq,
        output ReadData, MemReady, MemErr, mmio_out
    );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data RAM with request/ready handshake and programmable wait states.
// Define MEM_MMIO_EN to map 32'hFFFF_FFF0 onto the mmio_out register.
module unified_mem_ctrl #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = "memfile.hex"
) (
    input  logic              clk,
    input  logic              reset,
    unified_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t        state, nextState;
    logic [3:0]    waitCnt, nextWaitCnt;
    logic [31:0]   latAddr, latData;
    logic          latWrite;
    logic [31:0]   mem [DEPTH];

    logic          accept, enterAccess;
    logic [31:0]   accAddr, accData;
    logic          accWrite;
    logic [AW-1:0] wordIdx;
    logic          aligned, inRange, isMmio, accErr;
    logic [31:0]   mmioVal;

    assign accept      = (state == IDLE) && bus.MemReq;
    assign enterAccess = (nextState == ACCESS);

    // With zero wait states the access happens on the accepting edge, so bypass the latches.
    assign accAddr  = (state == IDLE) ? bus.Address   : latAddr;
    assign accData  = (state == IDLE) ? bus.WriteData : latData;
    assign accWrite = (state == IDLE) ? bus.MemWrite  : latWrite;

    assign wordIdx = accAddr[AW+1:2];
    assign aligned = (accAddr[1:0] == 2'b00);
    assign inRange = (accAddr[31:AW+2] == '0);

`ifdef MEM_MMIO_EN
    logic [31:0] mmioReg;

    assign isMmio  = (accAddr == 32'hFFFF_FFF0);
    assign mmioVal = mmioReg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mmioReg <= '0;
        end else if (enterAccess && accWrite && isMmio) begin
            mmioReg <= accData;
        end
    end
`else
    assign isMmio  = 1'b0;
    assign mmioVal = '0;
`endif

    assign accErr       = !isMmio && (!aligned || !inRange);
    assign bus.mmio_out = mmioVal;

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            IDLE: begin
                if (bus.MemReq) begin
                    if (WAIT_CYCLES == 0) begin
                        nextState = ACCESS;
                    end else begin
                        nextState   = WAIT;
                        nextWaitCnt = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    nextState = ACCESS;
                end else begin
                    nextWaitCnt = waitCnt - 4'd1;
                end
            end
            ACCESS:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Access results are registered on the edge into ACCESS, so they are visible during it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            waitCnt      <= '0;
            latAddr      <= '0;
            latData      <= '0;
            latWrite     <= 1'b0;
            bus.ReadData <= '0;
            bus.MemReady <= 1'b0;
            bus.MemErr   <= 1'b0;
        end else begin
            state        <= nextState;
            waitCnt      <= nextWaitCnt;
            bus.MemReady <= enterAccess;
            if (accept) begin
                latAddr  <= bus.Address;
                latData  <= bus.WriteData;
                latWrite <= bus.MemWrite;
            end
            if (enterAccess) begin
                if (accErr) begin
                    bus.MemErr <= 1'b1;
                end
                if (!accWrite) begin
                    bus.ReadData <= accErr ? 32'h0 : (isMmio ? mmioVal : mem[wordIdx]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && enterAccess && accWrite && !accErr && !isMmio) begin
            mem[wordIdx] <= accData;
        end
    end
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed + randomized bench for unified_mem_ctrl against a word-array reference model.
// Expectations for 32'hFFFF_FFF0 follow whether MEM_MMIO_EN is defined.
module tb_unified_mem_ctrl;
    localparam int DEPTH = 16;
    localparam int WAITS = 2;
`ifdef MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    unified_mem_ctrl_if bus();

    unified_mem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITS),
        .INIT_FILE   ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] refMem [DEPTH];
    logic [31:0] refRead;
    logic        refErr;
    logic [31:0] refMmio;
    int          checkCount = 0;
    int          passCount  = 0;

    function automatic bit isMmioAddr(input logic [31:0] addr);
        return MMIO_EN && (addr == 32'hFFFF_FFF0);
    endfunction

    function automatic bit isBadAddr(input logic [31:0] addr);
        return !isMmioAddr(addr) && ((addr % 4 != 0) || (addr >= 32'(4 * DEPTH)));
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr);
        if (isMmioAddr(addr)) return refMmio;
        if (isBadAddr(addr))  return 32'h0;
        return refMem[addr / 4];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // One complete transaction: request, wait for MemReady, then compare with the model.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wr, input string tag);
        int cycles;
        @(negedge clk);
        bus.Address   = addr;
        bus.WriteData = data;
        bus.MemWrite  = wr;
        bus.MemReq    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.MemReq = 1'b0;
        cycles = 1;
        while (bus.MemReady !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (!wr) refRead = refLoad(addr);
        if (isBadAddr(addr)) refErr = 1'b1;
        else if (wr && isMmioAddr(addr)) refMmio = data;
        else if (wr) refMem[addr / 4] = data;
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(WAITS + 1));
        checkOutput({tag, "_rdata"}, bus.ReadData, refRead);
        checkOutput({tag, "_err"}, {31'b0, bus.MemErr}, {31'b0, refErr});
        @(posedge clk);
    endtask

    initial begin
        int readyTimes[$];
        int extraReady;
        logic [31:0] addr;

        reset         = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.MemReq    = 1'b0;
        refRead       = '0;
        refErr        = 1'b0;
        refMmio       = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdata", bus.ReadData, 32'h0);
        checkOutput("reset_ready", {31'b0, bus.MemReady}, 32'h0);
        checkOutput("reset_err", {31'b0, bus.MemErr}, 32'h0);
        checkOutput("reset_mmio", bus.mmio_out, 32'h0);
        reset = 1'b1;

        // Known contents for every word, since the bench runs without a preload image.
        for (int i = 0; i < DEPTH; i++) applyStimulus(32'(4 * i), $urandom, 1'b1, "fill");
        applyStimulus(32'h0, 32'h0, 1'b0, "load_word0");

        applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, "store_10");
        applyStimulus(32'h10, 32'h0, 1'b0, "load_10");
        checkOutput("deadbeef", bus.ReadData, 32'hDEADBEEF);

        // MemReq held high across two loads: one pulse each, WAITS+2 cycles apart.
        @(negedge clk);
        bus.Address  = 32'h0;
        bus.MemWrite = 1'b0;
        bus.MemReq   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.MemReady === 1'b1) begin
                readyTimes.push_back(c);
                if (readyTimes.size() == 1) begin
                    checkOutput("held_rdata0", bus.ReadData, refMem[0]);
                    bus.Address = 32'h4;
                end else if (readyTimes.size() == 2) begin
                    checkOutput("held_rdata1", bus.ReadData, refMem[1]);
                    bus.MemReq = 1'b0;
                end
            end
        end
        refRead = refMem[1];
        checkOutput("held_count", 32'(readyTimes.size()), 32'd2);
        if (readyTimes.size() == 2) begin
            checkOutput("held_first", 32'(readyTimes[0]), 32'(WAITS + 1));
            checkOutput("held_spacing", 32'(readyTimes[1] - readyTimes[0]), 32'(WAITS + 2));
        end

        applyStimulus(32'h6, 32'h0, 1'b0, "misaligned_load");
        applyStimulus(32'(4 * DEPTH), 32'hA5A5A5A5, 1'b1, "range_store");
        applyStimulus(32'(4 * (DEPTH - 1)), 32'h0, 1'b0, "last_word");
        checkOutput("err_sticky", {31'b0, bus.MemErr}, 32'h1);

        // Reset during WAIT aborts the pending store and produces no MemReady.
        @(negedge clk);
        bus.Address   = 32'h20;
        bus.WriteData = 32'h1234;
        bus.MemWrite  = 1'b1;
        bus.MemReq    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.MemReq = 1'b0;
        reset      = 1'b0;
        extraReady = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.MemReady === 1'b1) extraReady++;
        end
        checkOutput("abort_no_ready", 32'(extraReady), 32'd0);
        checkOutput("abort_err_clr", {31'b0, bus.MemErr}, 32'h0);
        reset   = 1'b1;
        refErr  = 1'b0;
        refRead = '0;
        refMmio = '0;
        applyStimulus(32'h20, 32'h0, 1'b0, "abort_reload");

        applyStimulus(32'hFFFF_FFF0, 32'h25, 1'b1, "mmio_store");
        checkOutput("mmio_out", bus.mmio_out, MMIO_EN ? 32'h25 : 32'h0);
        applyStimulus(32'hFFFF_FFF0, 32'h0, 1'b0, "mmio_load");
        checkOutput("mmio_err", {31'b0, bus.MemErr}, MMIO_EN ? 32'h0 : 32'h1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0:       addr = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1;
                1:       addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 15));
                default: addr = 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            applyStimulus(addr, $urandom, 1'($urandom_range(0, 1)), "random");
        end
        checkOutput("final_mmio", bus.mmio_out, refMmio);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
